// File: rtl/decoder524_scan_arbiter.sv
// Round-robin arbiter sharing one decoder524 among up to 24 requesters.
// Grants are held until done, request drop or MAX_HOLD, followed by GAP_CYCLES disabled cycles.
module decoder524_scan_arbiter #(
    parameter int NCH        = 24,
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] req,
    input  logic        done,
    output logic [4:0]  a,
    output logic        sta,
    output logic        stb,
    output logic        stc,
    output logic        busy,
    output logic [4:0]  gnt_id,
    output logic        timeout
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    localparam logic [23:0] CH_MASK = 24'((25'd1 << NCH) - 25'd1);

    state_t      r_state;
    logic [4:0]  r_ptr;
    logic [4:0]  r_gnt_id;
    logic [7:0]  r_hold_cnt;
    logic [3:0]  r_gap_cnt;
    logic        r_sta;
    logic        r_stb;
    logic        r_stc;
    logic        r_busy;
    logic        r_timeout;

    logic [23:0] w_req_m;
    logic        w_any;
    logic [4:0]  w_winner;
    logic        w_own_req;
    logic        w_hold_max;
    logic        w_gap_end;
    logic        w_release;

    // Channel id at circular distance off from p, wrapping at NCH.
    function automatic logic [4:0] wrap_idx(input logic [4:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NCH) s = s - NCH;
        return 5'(s);
    endfunction

    assign w_req_m    = req & CH_MASK;
    assign w_own_req  = w_req_m[r_gnt_id];
    assign w_hold_max = (r_hold_cnt == 8'(MAX_HOLD - 1));
    assign w_gap_end  = (r_gap_cnt == 4'(GAP_CYCLES - 1));
    assign w_release  = done || !w_own_req || w_hold_max;

    // Scan from the farthest offset down so the nearest requester after r_ptr wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int off = NCH; off >= 1; off--) begin
            if (w_req_m[wrap_idx(r_ptr, off)]) begin
                w_any    = 1'b1;
                w_winner = wrap_idx(r_ptr, off);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 5'(NCH - 1);
            r_gnt_id   <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_sta      <= 1'b0;
            r_stb      <= 1'b1;
            r_stc      <= 1'b1;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                // The last gap cycle arbitrates directly so grants are exactly GAP_CYCLES apart.
                S_IDLE, S_GAP: begin
                    if (r_state == S_GAP && !w_gap_end) begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end else if (w_any) begin
                        r_state    <= S_GRANT;
                        r_gnt_id   <= w_winner;
                        r_hold_cnt <= '0;
                        r_sta      <= 1'b1;
                        r_stb      <= 1'b0;
                        r_stc      <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state   <= S_GAP;
                        r_ptr     <= r_gnt_id;
                        r_gap_cnt <= '0;
                        r_sta     <= 1'b0;
                        r_stb     <= 1'b1;
                        r_stc     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_timeout <= !done && w_own_req;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign a       = r_gnt_id;
    assign gnt_id  = r_gnt_id;
    assign sta     = r_sta;
    assign stb     = r_stb;
    assign stc     = r_stc;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_decoder524_scan_arbiter.sv
// Bench for decoder524_scan_arbiter: directed scenarios plus random traffic on two
// configurations, checked cycle by cycle against a grant-ownership reference model.
module tb_decoder524_scan_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] req;
    logic        done;
    logic [4:0]  a, gnt_id, a8, gnt8;
    logic        sta, stb, stc, busy, timeout;
    logic        sta8, stb8, stc8, busy8, to8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder524_scan_arbiter #(.NCH(24), .MAX_HOLD(16), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .a(a), .sta(sta), .stb(stb), .stc(stc),
        .busy(busy), .gnt_id(gnt_id), .timeout(timeout)
    );

    decoder524_scan_arbiter #(.NCH(8), .MAX_HOLD(5), .GAP_CYCLES(2)) dut8 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .a(a8), .sta(sta8), .stb(stb8), .stc(stc8),
        .busy(busy8), .gnt_id(gnt8), .timeout(to8)
    );

    // owner = channel holding the decoder (-1 none); age = cycles granted so far;
    // gap_left = disabled cycles still owed; last = most recently released channel.
    typedef struct packed {
        int owner;
        int shown;
        int age;
        int gap_left;
        int last;
        bit to;
    } m_t;

    m_t m24 = '0;
    m_t m8  = '0;

    function automatic m_t mstep(m_t m, int nch, int maxh, int gapc,
                                 logic [23:0] rq, logic dn, logic rs);
        m_t n;
        int c;
        n = m;
        n.to = 1'b0;
        if (rs) begin
            n.owner = -1; n.shown = 0; n.age = 0; n.gap_left = 0; n.last = nch - 1;
            return n;
        end
        if (m.owner >= 0) begin
            if (dn || !rq[m.owner] || m.age == maxh) begin
                n.to       = !dn && rq[m.owner];
                n.last     = m.owner;
                n.owner    = -1;
                n.gap_left = gapc;
            end else begin
                n.age = m.age + 1;
            end
        end else if (m.gap_left > 1) begin
            n.gap_left = m.gap_left - 1;
        end else begin
            n.gap_left = 0;
            for (int k = 1; k <= nch; k++) begin
                c = (m.last + k) % nch;
                if (rq[c] && n.owner < 0) begin
                    n.owner = c; n.shown = c; n.age = 1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [14:0] mexp(m_t m);
        logic en;
        en = (m.owner >= 0);
        return {5'(m.shown), en, !en, !en, en, 5'(m.shown), m.to};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [23:0] rq, input logic dn, input logic rs);
        req = rq; done = dn; rst = rs;
        @(posedge clk);
        m24 = mstep(m24, 24, 16, 1, rq, dn, rs);
        m8  = mstep(m8, 8, 5, 2, rq, dn, rs);
        @(negedge clk);
        chk("model24", {17'd0, a, sta, stb, stc, busy, gnt_id, timeout}, {17'd0, mexp(m24)});
        chk("model8", {17'd0, a8, sta8, stb8, stc8, busy8, gnt8, to8}, {17'd0, mexp(m8)});
        if (busy8 === 1'b1) chk("nch8_range", {31'd0, (a8 < 5'd8)}, 32'd1);
    endtask

    int          order [5];
    int          ng;
    logic        pb;
    logic        b [40];
    logic        t [40];
    int          f, len, tcnt;
    logic [23:0] rq_r;
    logic        dn_r, rs_r;

    initial begin
        // Test 1: reset, idle with no requests
        cyc(24'h0, 1'b0, 1'b1);
        cyc(24'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(24'h0, 1'b0, 1'b0);
            chk("t1_idle", {23'd0, a, sta, stb, stc, busy}, {23'd0, 5'd0, 4'b0110});
        end

        // Test 2: single requester, done pulse, regrant after one gap cycle
        cyc(24'h000001, 1'b0, 1'b0);
        chk("t2_enable", {23'd0, a, sta, stb, stc, busy}, {23'd0, 5'd0, 4'b1001});
        cyc(24'h000001, 1'b0, 1'b0);
        cyc(24'h000001, 1'b0, 1'b0);
        cyc(24'h000001, 1'b1, 1'b0);
        chk("t2_release", {31'd0, busy}, 32'd0);
        cyc(24'h000001, 1'b0, 1'b0);
        chk("t2_regrant", {26'd0, a, busy}, {26'd0, 5'd0, 1'b1});

        // Test 3: rotation order with a done on every grant
        cyc(24'h0, 1'b0, 1'b1);
        ng = 0;
        pb = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cyc(24'h800005, busy === 1'b1, 1'b0);
            if (busy === 1'b1 && !pb && ng < 5) begin
                order[ng] = int'(a);
                ng++;
            end
            pb = busy;
        end
        chk("t3_count", 32'(ng), 32'd5);
        chk("t3_g0", 32'(order[0]), 32'd0);
        chk("t3_g1", 32'(order[1]), 32'd2);
        chk("t3_g2", 32'(order[2]), 32'd23);
        chk("t3_g3", 32'(order[3]), 32'd0);
        chk("t3_g4", 32'(order[4]), 32'd2);

        // Test 4: lone requester without done hits MAX_HOLD
        cyc(24'h0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cyc(24'h000010, 1'b0, 1'b0);
            b[i] = busy;
            t[i] = timeout;
        end
        f = -1;
        for (int i = 0; i < 40; i++) if (b[i] === 1'b1 && f < 0) f = i;
        if (f < 0) f = 0;
        len = 0;
        tcnt = 0;
        for (int i = f; i < 40 && b[i] === 1'b1; i++) begin
            len++;
            if (t[i] === 1'b1) tcnt++;
        end
        chk("t4_first", 32'(f), 32'd0);
        chk("t4_len", 32'(len), 32'd16);
        chk("t4_no_early_to", 32'(tcnt), 32'd0);
        if (f + len < 39) begin
            chk("t4_to_pulse", {31'd0, t[f + len]}, 32'd1);
            chk("t4_regrant", {31'd0, b[f + len + 1]}, 32'd1);
            chk("t4_to_clear", {31'd0, t[f + len + 1]}, 32'd0);
        end else begin
            chk("t4_window", 32'(f + len), 32'd16);
        end

        // Test 5: request drop mid-grant
        cyc(24'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(24'h000080, 1'b0, 1'b0);
        chk("t5_gnt", {26'd0, a, busy}, {26'd0, 5'd7, 1'b1});
        cyc(24'h0, 1'b0, 1'b0);
        chk("t5_off", {29'd0, sta, busy, timeout}, 32'd0);

        // Test 6: reset mid-grant, then all requests
        cyc(24'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(24'h000020, 1'b0, 1'b0);
        chk("t6_gnt", {26'd0, a, busy}, {26'd0, 5'd5, 1'b1});
        cyc(24'h000020, 1'b0, 1'b1);
        chk("t6_reset", {17'd0, a, sta, stb, stc, busy, gnt_id, timeout},
            {17'd0, 5'd0, 4'b0110, 5'd0, 1'b0});
        cyc(24'hFFFFFF, 1'b0, 1'b0);
        chk("t6_first", {26'd0, a, busy}, {26'd0, 5'd0, 1'b1});
        for (int i = 0; i < 30; i++) cyc(24'hFFFFFF, ($urandom_range(0, 3) == 0), 1'b0);

        // Random traffic
        rq_r = 24'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rq_r = 24'($urandom & $urandom);
            dn_r = ($urandom_range(0, 7) == 0);
            rs_r = ($urandom_range(0, 199) == 0);
            cyc(rq_r, dn_r, rs_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
